// File: rtl/operand_issue.sv
// Operand issue stage: scoreboard hazard check, regfile read with
// same-edge writeback bypass, and a one-entry output register to execute.
module operand_issue #(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic                 dec_rs1_en,
    input  logic [4:0]           dec_rs1_addr,
    input  logic                 dec_rs2_en,
    input  logic [4:0]           dec_rs2_addr,
    input  logic                 dec_rd_en,
    input  logic [4:0]           dec_rd_addr,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic                 rs1_en,
    output logic [4:0]           rs1_addr,
    input  logic [31:0]          rs1_data,
    output logic                 rs2_en,
    output logic [4:0]           rs2_addr,
    input  logic [31:0]          rs2_data,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [31:0]          wb_data,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [31:0]          ex_rs1_data,
    output logic [31:0]          ex_rs2_data,
    output logic                 ex_rd_en,
    output logic [4:0]           ex_rd_addr,
    output logic [PAYLOAD_W-1:0] ex_payload,
    input  logic                 flush
);

    logic [31:1]          r_busy;
    logic                 r_ex_valid;
    logic [31:0]          r_ex_rs1;
    logic [31:0]          r_ex_rs2;
    logic                 r_ex_rd_en;
    logic [4:0]           r_ex_rd_addr;
    logic [PAYLOAD_W-1:0] r_ex_payload;

    logic [31:0] w_busy;
    logic [31:0] w_busy_nxt;
    logic        w_hit1;
    logic        w_hit2;
    logic        w_hitd;
    logic        w_hitw;
    logic        w_hz1;
    logic        w_hz2;
    logic        w_hzw;
    logic        w_issue;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    function automatic logic f_hit(input logic       en,
                                   input logic [4:0] wa,
                                   input logic [4:0] a);
        return en && (wa == a) && (a != 5'd0);
    endfunction

    // x0 is never busy, so the scoreboard is padded with a constant zero
    assign w_busy = {r_busy, 1'b0};

    assign rs1_en   = dec_valid & dec_rs1_en;
    assign rs1_addr = dec_rs1_addr;
    assign rs2_en   = dec_valid & dec_rs2_en;
    assign rs2_addr = dec_rs2_addr;

    assign w_hit1 = f_hit(wb_en, wb_addr, dec_rs1_addr);
    assign w_hit2 = f_hit(wb_en, wb_addr, dec_rs2_addr);
    assign w_hitd = f_hit(wb_en, wb_addr, dec_rd_addr);
    assign w_hitw = f_hit(wb_en, wb_addr, wb_addr);

    // A writeback landing this cycle resolves the hazard it would cause
    assign w_hz1 = dec_rs1_en & (dec_rs1_addr != 5'd0)
                 & w_busy[dec_rs1_addr] & ~w_hit1;
    assign w_hz2 = dec_rs2_en & (dec_rs2_addr != 5'd0)
                 & w_busy[dec_rs2_addr] & ~w_hit2;
    assign w_hzw = dec_rd_en & (dec_rd_addr != 5'd0)
                 & w_busy[dec_rd_addr] & ~w_hitd;

    assign dec_ready = ~flush & ~(w_hz1 | w_hz2 | w_hzw)
                     & (~r_ex_valid | ex_ready);
    assign w_issue   = dec_valid & dec_ready;

    // Operand select: bypass the writeback value over the stale regfile read
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        if (dec_rs1_en && dec_rs1_addr != 5'd0)
            w_op1 = w_hit1 ? wb_data : rs1_data;
        if (dec_rs2_en && dec_rs2_addr != 5'd0)
            w_op2 = w_hit2 ? wb_data : rs2_data;
    end

    // Scoreboard next state: clears first, so a same-cycle set wins
    always_comb begin
        w_busy_nxt = w_busy;
        if (w_hitw)
            w_busy_nxt[wb_addr] = 1'b0;
        if (flush && r_ex_valid && r_ex_rd_en && r_ex_rd_addr != 5'd0)
            w_busy_nxt[r_ex_rd_addr] = 1'b0;
        if (w_issue && dec_rd_en && dec_rd_addr != 5'd0)
            w_busy_nxt[dec_rd_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt[31:1];
    end

    // Output register toward execute; held while execute stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_ex_rd_en   <= 1'b0;
            r_ex_rd_addr <= '0;
            r_ex_payload <= '0;
        end else if (w_issue) begin
            r_ex_valid   <= 1'b1;
            r_ex_rs1     <= w_op1;
            r_ex_rs2     <= w_op2;
            r_ex_rd_en   <= dec_rd_en;
            r_ex_rd_addr <= dec_rd_addr;
            r_ex_payload <= dec_payload;
        end else if (flush || ex_ready) begin
            r_ex_valid   <= 1'b0;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_rs1_data = r_ex_rs1;
    assign ex_rs2_data = r_ex_rs2;
    assign ex_rd_en    = r_ex_rd_en;
    assign ex_rd_addr  = r_ex_rd_addr;
    assign ex_payload  = r_ex_payload;

endmodule
